// File: rtl/ifft_8pt_serial.sv
// ifft_8pt_serial: 8-point radix-2 DIT inverse FFT, one shared butterfly over an in-place frame buffer
module ifft_8pt_serial #(
    parameter int DW   = 12,
    parameter int TW_C = 181
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last
);
    localparam int W = DW + 10;
    localparam logic signed [W-1:0] TWC  = W'(TW_C);
    localparam logic signed [W-1:0] MAXV = W'((1 << (DW - 1)) - 1);
    localparam logic signed [W-1:0] MINV = -MAXV - W'(1);

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

    state_t state, state_nx;
    logic signed [DW-1:0] mem_re [8];
    logic signed [DW-1:0] mem_im [8];
    logic [2:0] cnt, ocnt, a, b;
    logic [1:0] stg, bj, k;
    logic last_bf;
    logic signed [W-1:0] ar, ai, br, bi, pd, ps, tr, ti;
    logic signed [DW-1:0] yr0, yi0, yr1, yi1;

    function automatic logic signed [DW-1:0] sat(input logic signed [W-1:0] v);
        return v > MAXV ? DW'(MAXV) : v < MINV ? DW'(MINV) : DW'(v);
    endfunction

    // Butterfly addressing, inverse twiddle multiply and halved, saturated butterfly outputs
    always_comb begin
        a   = stg == 2'd0 ? {bj, 1'b0} : stg == 2'd1 ? {bj[1], 1'b0, bj[0]} : {1'b0, bj};
        b   = a | (3'b001 << stg);
        k   = stg == 2'd0 ? 2'd0 : stg == 2'd1 ? {bj[0], 1'b0} : bj;
        ar  = mem_re[a];
        ai  = mem_im[a];
        br  = mem_re[b];
        bi  = mem_im[b];
        pd  = (br - bi) * TWC;
        ps  = (br + bi) * TWC;
        tr  = k == 2'd0 ? br : k == 2'd1 ? pd >>> 8 : k == 2'd2 ? -bi : (-ps) >>> 8;
        ti  = k == 2'd0 ? bi : k == 2'd1 ? ps >>> 8 : k == 2'd2 ? br  : pd >>> 8;
        yr0 = sat((ar + tr) >>> 1);
        yi0 = sat((ai + ti) >>> 1);
        yr1 = sat((ar - tr) >>> 1);
        yi1 = sat((ai - ti) >>> 1);
        last_bf = stg == 2'd2 && bj == 2'd3;
    end

    // Next-state and handshake/output decode
    always_comb begin
        state_nx  = state;
        in_ready  = state == LOAD;
        out_valid = state == OUT;
        out_last  = state == OUT && ocnt == 3'd7;
        out_re    = state == OUT ? mem_re[ocnt] : '0;
        out_im    = state == OUT ? mem_im[ocnt] : '0;
        state_nx  = state == LOAD && in_valid && cnt == 3'd7      ? CALC :
                    state == CALC && last_bf                      ? OUT  :
                    state == OUT && out_ready && ocnt == 3'd7     ? LOAD : state;
    end

    // State, counters and in-place buffer updates (bit-reversed load, butterfly write-back)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= '0;
            ocnt  <= '0;
            stg   <= '0;
            bj    <= '0;
            for (int i = 0; i < 8; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == LOAD && in_valid) begin
                mem_re[{cnt[0], cnt[1], cnt[2]}] <= in_re;
                mem_im[{cnt[0], cnt[1], cnt[2]}] <= in_im;
                cnt <= cnt + 3'd1;
            end
            if (state == CALC) begin
                mem_re[a] <= yr0;
                mem_im[a] <= yi0;
                mem_re[b] <= yr1;
                mem_im[b] <= yi1;
                {stg, bj} <= last_bf ? 4'd0 : {stg, bj} + 4'd1;
            end
            if (state == OUT && out_ready)
                ocnt <= ocnt + 3'd1;
        end
    end
endmodule
